// File: rtl/clock_stretch_divider_mux.sv
// Derives CHANNELS independent divided clocks from clock_in; each channel's ratio and polarity can be
// reconfigured without glitches. Latency: clock_out/tick are registered; a config is applied at the
// next phase boundary (or the next cycle when the channel is idle). cfg_ready drops while the target channel is busy.
module clock_stretch_divider_mux #(
    parameter int          CHANNELS  = 2,
    parameter int          DIV_WIDTH = 8,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2:0]           cfg_channel,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_invert,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  busy
);

    typedef enum logic {IDLE, RUN} state_t;

    logic [CHANNELS-1:0] ready_vec;

    // Out-of-range channel indices match no channel, so ready stays low for them.
    assign cfg_ready = |ready_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t               state;
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] div_cur;
        logic [DIV_WIDTH-1:0] pend_div;
        logic                 level;
        logic                 inv_cur;
        logic                 pend_valid;
        logic                 pend_inv;
        logic                 tick_q;
        logic                 sel;
        logic                 accept;

        assign sel          = (cfg_channel == 3'(i));
        assign ready_vec[i] = sel & ~pend_valid;
        assign accept       = cfg_valid & ready_vec[i];
        assign clock_out[i] = level;
        assign tick[i]      = tick_q;
        assign busy[i]      = pend_valid;

        always_ff @(posedge clock_in) begin
            if (reset) begin
                state      <= IDLE;
                cnt        <= '0;
                level      <= 1'b0;
                div_cur    <= DIV_WIDTH'(DIV_RESET);
                inv_cur    <= 1'b0;
                pend_valid <= 1'b0;
                pend_div   <= '0;
                pend_inv   <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                // Accept only happens with pend_valid low, so it never collides with an apply below.
                if (accept) begin
                    pend_valid <= 1'b1;
                    pend_div   <= cfg_div;
                    pend_inv   <= cfg_invert;
                end
                case (state)
                    IDLE: begin
                        if (pend_valid) begin
                            div_cur    <= pend_div;
                            inv_cur    <= pend_inv;
                            level      <= pend_inv;
                            tick_q     <= pend_inv & ~level;
                            pend_valid <= 1'b0;
                        end else if (enable[i]) begin
                            level  <= ~inv_cur;
                            tick_q <= ~inv_cur & ~level;
                            cnt    <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (cnt != div_cur) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt <= '0;
                            if (!enable[i]) begin
                                level  <= inv_cur;
                                tick_q <= inv_cur & ~level;
                                state  <= IDLE;
                            end else if (pend_valid) begin
                                div_cur    <= pend_div;
                                pend_valid <= 1'b0;
                                // A polarity change holds the level for one more phase instead of toggling.
                                if (pend_inv != inv_cur) begin
                                    inv_cur <= pend_inv;
                                end else begin
                                    level  <= ~level;
                                    tick_q <= ~level;
                                end
                            end else begin
                                level  <= ~level;
                                tick_q <= ~level;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_stretch_divider_mux.sv
// Directed plus randomized bench for clock_stretch_divider_mux against a phase-countdown reference model.
module tb_clock_stretch_divider_mux;
    localparam int CH = 2;
    localparam int DW = 8;
    localparam int DR = 0;

    logic          clock_in = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_channel;
    logic [DW-1:0] cfg_div;
    logic          cfg_invert;
    logic [CH-1:0] clock_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;

    int errors = 0;
    int checks = 0;

    always #5 clock_in = ~clock_in;

    clock_stretch_divider_mux #(
        .CHANNELS (CH),
        .DIV_WIDTH(DW),
        .DIV_RESET(DR)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_div    (cfg_div),
        .cfg_invert (cfg_invert),
        .clock_out  (clock_out),
        .tick       (tick),
        .busy       (busy)
    );

    // Reference model: each running channel counts down the cycles left in its current phase.
    logic [CH-1:0] m_run, m_lvl, m_inv, m_pv, m_pinv, m_tick;
    int            m_left [CH];
    int            m_div  [CH];
    int            m_pdiv [CH];

    function automatic bit m_ready();
        int ch;
        ch = int'(cfg_channel);
        if (ch >= CH) return 1'b0;
        return !m_pv[ch];
    endfunction

    always @(posedge clock_in) begin : ref_model
        bit   acc;
        int   ch;
        logic old;
        if (reset) begin
            m_run = '0; m_lvl = '0; m_inv = '0; m_pv = '0; m_pinv = '0; m_tick = '0;
            for (int c = 0; c < CH; c++) begin
                m_left[c] = 0; m_div[c] = DR; m_pdiv[c] = 0;
            end
        end else begin
            acc = cfg_valid && m_ready();
            ch  = int'(cfg_channel);
            for (int c = 0; c < CH; c++) begin
                old = m_lvl[c];
                if (!m_run[c]) begin
                    if (m_pv[c]) begin
                        m_div[c] = m_pdiv[c]; m_inv[c] = m_pinv[c]; m_lvl[c] = m_pinv[c]; m_pv[c] = 1'b0;
                    end else if (enable[c]) begin
                        m_lvl[c] = ~m_inv[c]; m_left[c] = m_div[c] + 1; m_run[c] = 1'b1;
                    end
                end else begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        if (!enable[c]) begin
                            m_lvl[c] = m_inv[c]; m_run[c] = 1'b0;
                        end else begin
                            if (m_pv[c]) begin
                                m_pv[c] = 1'b0; m_div[c] = m_pdiv[c];
                                if (m_pinv[c] != m_inv[c]) m_inv[c] = m_pinv[c];
                                else m_lvl[c] = ~m_lvl[c];
                            end else begin
                                m_lvl[c] = ~m_lvl[c];
                            end
                            m_left[c] = m_div[c] + 1;
                        end
                    end
                end
                m_tick[c] = m_lvl[c] & ~old;
            end
            if (acc) begin
                m_pv[ch] = 1'b1; m_pdiv[ch] = int'(cfg_div); m_pinv[ch] = cfg_invert;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        @(posedge clock_in);
        @(negedge clock_in);
        check("clock_out", 32'(clock_out), 32'(m_lvl));
        check("tick", 32'(tick), 32'(m_tick));
        check("busy", 32'(busy), 32'(m_pv));
    endtask

    task automatic wait_rise(input int ch);
        int k;
        k = 0;
        while (tick[ch] !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("rise_seen", 32'(tick[ch]), 32'd1);
    endtask

    task automatic phase_len(input int ch, output int n);
        logic v;
        v = clock_out[ch];
        n = 0;
        while (clock_out[ch] === v && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic send_cfg(input int ch, input int d, input bit inv);
        cfg_channel = 3'(ch); cfg_div = DW'(d); cfg_invert = inv; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int r;
        int n;
        reset = 1'b1; enable = '0; cfg_valid = 1'b0; cfg_channel = '0; cfg_div = '0; cfg_invert = 1'b0;
        repeat (2) begin
            @(posedge clock_in);
            @(negedge clock_in);
        end
        reset = 1'b0;
        #1;
        check("rst_clock_out", 32'(clock_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // D=0 on ch0: one tick every second cycle, ch1 stays low
        send_cfg(0, 0, 1'b0);
        repeat (2) step();
        enable = 2'b01;
        n = 0;
        repeat (8) begin
            step();
            n += int'(tick[0]);
        end
        check("d0_tick_count", 32'(n), 32'd4);
        check("d0_ch1_low", 32'(clock_out[1]), 32'd0);

        // D=3 then reconfigure to D=1 inside a high phase
        send_cfg(0, 3, 1'b0);
        repeat (4) step();
        wait_rise(0);
        send_cfg(0, 1, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        #1;
        check("cfg_stall", 32'(cfg_ready), 32'd0);
        step();
        cfg_valid = 1'b0;
        phase_len(0, r);
        check("stretch_high_d3", 32'(2 + r), 32'd4);
        check("busy_cleared", 32'(busy[0]), 32'd0);
        phase_len(0, r);
        check("d1_low", 32'(r), 32'd2);
        phase_len(0, r);
        check("d1_high", 32'(r), 32'd2);

        // polarity change at D=2 stretches one phase to 6 cycles
        send_cfg(0, 2, 1'b0);
        repeat (6) step();
        wait_rise(0);
        send_cfg(0, 2, 1'b1);
        phase_len(0, r);
        check("invert_stretch", 32'(1 + r), 32'd6);
        phase_len(0, r);
        check("inv_phase_a", 32'(r), 32'd3);
        phase_len(0, r);
        check("inv_phase_b", 32'(r), 32'd3);

        // enable dropped mid-phase: ch0 parks low, inverted ch1 parks high
        enable = 2'b00;
        repeat (12) step();
        send_cfg(0, 4, 1'b0);
        send_cfg(1, 4, 1'b1);
        repeat (2) step();
        enable = 2'b11;
        step();
        check("start_levels", 32'(clock_out), 32'h1);
        step();
        enable = 2'b00;
        phase_len(0, r);
        check("drop_high_len", 32'(1 + r), 32'd5);
        check("park_levels", 32'(clock_out), 32'h2);
        repeat (8) step();
        check("park_hold", 32'(clock_out), 32'h2);

        // ch1 configurable while ch0 is busy; out-of-range channel never ready
        enable = 2'b01;
        repeat (2) step();
        send_cfg(0, 4, 1'b0);
        cfg_channel = 3'd1; cfg_div = 8'd5; cfg_invert = 1'b0; cfg_valid = 1'b1;
        #1;
        check("ch1_ready_while_ch0_busy", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("ch0_still_busy", 32'(busy[0]), 32'd1);
        enable = 2'b11;
        step();
        wait_rise(1);
        step();
        n = 1;
        while (tick[1] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("ch1_period_d5", 32'(n), 32'd12);
        cfg_channel = 3'd7; cfg_valid = 1'b1;
        #1;
        check("ch7_not_ready", 32'(cfg_ready), 32'd0);
        step();
        cfg_valid = 1'b0;

        // randomized traffic, every cycle compared against the model
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) enable = CH'($urandom);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_channel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            cfg_div     = DW'($urandom_range(0, 5));
            cfg_invert  = 1'($urandom);
            step();
        end
        cfg_valid = 1'b0;

        // reset mid-run with a config pending
        enable = 2'b01;
        repeat (4) step();
        cfg_channel = 3'd0; cfg_div = 8'd7; cfg_invert = 1'b1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        reset = 1'b1;
        step();
        check("midrst_clock_out", 32'(clock_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        step();
        check("restart_high", 32'(clock_out), 32'h1);
        phase_len(0, r);
        check("restart_div_reset", 32'(r), 32'(DR + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
